tinyqv_mem_arbiter: RTL

//  Shares the single QSPI memory-controller port between the CPU instruction-fetch stream and CPU data loads/stores.

---
 rtl/tinyqv_mem_arbiter_pkg.sv | 19 +
 rtl/tinyqv_read_assembler.sv | 39 +++
 rtl/tinyqv_mem_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/tinyqv_mem_arbiter_pkg.sv
// Shared types for the TinyQV memory arbiter: size codes and arbiter state encoding.
// Pure definitions, no logic; sizes follow the CPU read_n/write_n encoding.
package tinyqv_mem_arbiter_pkg;

   localparam logic [1:0] SIZE_8    = 2'b00;
   localparam logic [1:0] SIZE_16   = 2'b01;
   localparam logic [1:0] SIZE_32   = 2'b10;
   localparam logic [1:0] SIZE_NONE = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_STOP  = 2'd2,
      ST_DATA  = 2'd3
   } arb_state_t;

   localparam int unsigned BEAT_CNT_BITS = 4;

endpackage

// File: rtl/tinyqv_read_assembler.sv
// Builds a load result from 16b beats (low half first), zero-extending 8/16b loads.
// Word and last are combinational with the final beat; no backpressure, beats are always taken.
module tinyqv_read_assembler
   import tinyqv_mem_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        beat,
   input  logic [15:0] rdata,
   input  logic [1:0]  size,
   output logic        last,
   output logic [31:0] word
);

   logic [15:0] low_q;
   logic        hi_q;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         low_q <= '0;
         hi_q  <= 1'b0;
      end else if (beat) begin
         low_q <= rdata;
         hi_q  <= 1'b1;
      end
   end

   always_comb begin
      word = '0;
      case (size)
         SIZE_32: word = {rdata, low_q};
         SIZE_16: word = {16'h0000, rdata};
         default: word = {24'h000000, rdata[7:0]};
      endcase
      last = beat && ((size != SIZE_32) || hi_q);
   end

endmodule

// File: rtl/tinyqv_mem_arbiter.sv
// Arbitrates the QSPI controller port between instruction fetch streams and data accesses (data first).
// Fetch beats pass through with zero latency; loads/stores acknowledge one cycle after completion.
module tinyqv_mem_arbiter
   import tinyqv_mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_BITS       = 25,
   parameter int unsigned FETCH_MIN_BEATS = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [23:1]          instr_addr,
   input  logic                 instr_fetch_restart,
   input  logic                 instr_fetch_stall,
   output logic                 instr_fetch_started,
   output logic                 instr_fetch_stopped,
   output logic [15:0]          instr_data_out,
   output logic                 instr_ready,
   input  logic [ADDR_BITS-1:0] data_addr,
   input  logic [1:0]           data_write_n,
   input  logic [1:0]           data_read_n,
   input  logic                 data_continue,
   input  logic [31:0]          data_wdata,
   output logic                 data_ready,
   output logic [31:0]          data_rdata,
   output logic                 mem_start,
   output logic                 mem_stream,
   output logic                 mem_write,
   output logic [1:0]           mem_size,
   output logic                 mem_continue,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [31:0]          mem_wdata,
   output logic                 mem_stop,
   input  logic                 mem_busy,
   input  logic                 mem_beat,
   input  logic [15:0]          mem_rdata,
   input  logic                 mem_done
);

   arb_state_t               state, state_n;
   logic [BEAT_CNT_BITS-1:0] beat_cnt;
   logic                     ack_hold;
   logic                     data_req;
   logic                     issue_data, issue_fetch, do_stop, rd_capture, wr_finish;
   logic                     asm_beat, asm_last;
   logic [31:0]              asm_word;

   // ack_hold masks the CPU request for the one cycle it still shows after data_ready.
   assign data_req = ((data_read_n != SIZE_NONE) || (data_write_n != SIZE_NONE)) && !ack_hold;

   assign instr_ready         = (state == ST_FETCH) && mem_beat;
   assign instr_data_out      = instr_ready ? mem_rdata : 16'h0000;
   assign instr_fetch_stopped = (state == ST_STOP) && !mem_busy;
   assign asm_beat            = (state == ST_DATA) && !mem_write && !data_ready && mem_beat;

   tinyqv_read_assembler u_asm (
      .clk   (clk),
      .rst   (rst),
      .clear (issue_data),
      .beat  (asm_beat),
      .rdata (mem_rdata),
      .size  (mem_size),
      .last  (asm_last),
      .word  (asm_word)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n     = state;
      issue_data  = 1'b0;
      issue_fetch = 1'b0;
      do_stop     = 1'b0;
      rd_capture  = 1'b0;
      wr_finish   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (data_req && !mem_busy) begin
               issue_data = 1'b1;
               state_n    = ST_DATA;
            end else if (instr_fetch_restart && !instr_fetch_stall && !mem_busy) begin
               issue_fetch = 1'b1;
               state_n     = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (instr_fetch_stall || !instr_fetch_restart ||
                (data_req && (32'(beat_cnt) >= FETCH_MIN_BEATS))) begin
               do_stop = 1'b1;
               state_n = ST_STOP;
            end
         end
         ST_STOP: begin
            if (!mem_busy) state_n = ST_IDLE;
         end
         ST_DATA: begin
            if (data_ready)                   state_n    = ST_IDLE;
            else if (!mem_write && asm_last)  rd_capture = 1'b1;
            else if (mem_write && mem_done)   wr_finish  = 1'b1;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_start           <= 1'b0;
         mem_stream          <= 1'b0;
         mem_write           <= 1'b0;
         mem_size            <= 2'b00;
         mem_continue        <= 1'b0;
         mem_addr            <= '0;
         mem_wdata           <= '0;
         mem_stop            <= 1'b0;
         instr_fetch_started <= 1'b0;
         data_ready          <= 1'b0;
         data_rdata          <= '0;
         ack_hold            <= 1'b0;
         beat_cnt            <= '0;
      end else begin
         mem_start           <= issue_data || issue_fetch;
         mem_stop            <= do_stop;
         instr_fetch_started <= issue_fetch;
         data_ready          <= rd_capture || wr_finish;
         ack_hold            <= data_ready;
         if (issue_data) begin
            mem_stream   <= 1'b0;
            mem_write    <= (data_write_n != SIZE_NONE);
            mem_size     <= (data_write_n != SIZE_NONE) ? data_write_n : data_read_n;
            mem_continue <= data_continue;
            mem_addr     <= data_addr;
            mem_wdata    <= data_wdata;
         end else if (issue_fetch) begin
            mem_stream   <= 1'b1;
            mem_write    <= 1'b0;
            mem_size     <= SIZE_16;
            mem_continue <= 1'b0;
            mem_addr     <= ADDR_BITS'({instr_addr, 1'b0});
         end
         if (rd_capture) data_rdata <= asm_word;
         if (issue_fetch)
            beat_cnt <= '0;
         else if ((state == ST_FETCH) && mem_beat && (beat_cnt != '1))
            beat_cnt <= beat_cnt + 1'b1;
      end
   end

endmodule
